// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one physical memory port.
// Contention alternates between the two sides, with the data side preferred on a tie after reset.
module cache_arbiter #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic              last_grant_d
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic              lgd_q, lgd_d;
   logic              grant_d, grant_i;

   // On a tie the side that did not win last time is granted.
   always_comb begin
      grant_d = (d_read | d_write) & (~i_read | ~lgd_q);
      grant_i = i_read & ~grant_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         lgd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         lgd_q   <= lgd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_d)      state_d = SERVE_D;
            else if (grant_i) state_d = SERVE_I;
         end
         SERVE_I, SERVE_D: begin
            if (pmem_resp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Grant-time capture; a write wins over a read when both are raised.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      lgd_d   = lgd_q;
      if (state_q == IDLE) begin
         if (grant_d) begin
            addr_d = d_address;
            wr_d   = d_write;
            lgd_d  = 1'b1;
            if (d_write) wdata_d = d_wdata;
         end else if (grant_i) begin
            addr_d = i_address;
            wr_d   = 1'b0;
            lgd_d  = 1'b0;
         end
      end
   end

   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      i_resp       = 1'b0;
      d_resp       = 1'b0;
      pmem_address = addr_q;
      pmem_wdata   = wdata_q;
      i_rdata      = pmem_rdata;
      d_rdata      = pmem_rdata;
      last_grant_d = lgd_q;
      case (state_q)
         SERVE_I: begin
            pmem_read = 1'b1;
            i_resp    = pmem_resp;
         end
         SERVE_D: begin
            pmem_read  = ~wr_q;
            pmem_write = wr_q;
            d_resp     = pmem_resp;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, physical address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache line width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_read  input  1  instruction-cache line fill request.
REQ-006 SHALL have port i_address  input  ADDR_W  instruction-cache line address.
REQ-007 SHALL have port i_rdata  output  LINE_W  fill data to instruction cache.
REQ-008 SHALL have port i_resp  output  1  instruction transaction done, one-cycle pulse.
REQ-009 SHALL have port d_read  input  1  data-cache line fill request.
REQ-010 SHALL have port d_write  input  1  data-cache line writeback request.
REQ-011 SHALL have port d_address  input  ADDR_W  data-cache line address.
REQ-012 SHALL have port d_wdata  input  LINE_W  writeback line.
REQ-013 SHALL have port d_rdata  output  LINE_W  fill data to data cache.
REQ-014 SHALL have port d_resp  output  1  data transaction done, one-cycle pulse.
REQ-015 SHALL have ports pmem_read, pmem_write  output  1 each  physical memory commands.
REQ-016 SHALL have port pmem_address  output  ADDR_W  latched address of granted transaction.
REQ-017 SHALL have port pmem_wdata  output  LINE_W  latched writeback line.
REQ-018 SHALL have port pmem_rdata  input  LINE_W  memory read data.
REQ-019 SHALL have port pmem_resp  input  1  memory done, one-cycle pulse.
REQ-020 SHALL have port last_grant_d  output  1  1 if most recent grant went to data side.

Function
REQ-021 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-022 In IDLE, a request SHALL be granted on the first rising edge it is sampled; grant latches address (and d_wdata for writes) into internal registers.
REQ-023 With only one side requesting in IDLE, that side SHALL be granted.
REQ-024 With both sides requesting in IDLE, data side SHALL win unless last_grant_d=1, in which case instruction side wins (alternate under contention).
REQ-025 last_grant_d SHALL update on every grant.
REQ-026 d_read and d_write both high SHALL be treated as write.
REQ-027 In SERVE_x, pmem_read or pmem_write (exactly one) SHALL be held high, with pmem_address/pmem_wdata from latched registers, until pmem_resp.
REQ-028 On pmem_resp in SERVE_I: i_resp=1 and i_rdata=pmem_rdata combinationally that cycle; next state IDLE. Likewise d_resp/d_rdata in SERVE_D.
REQ-029 i_resp and d_resp SHALL never be high simultaneously nor outside the matching SERVE state.
REQ-030 pmem_resp in IDLE SHALL be ignored.
REQ-031 Requester SHALL hold request until its resp; deasserting mid-transaction SHALL NOT abort it, resp still pulses.
REQ-032 Input address/data changes after grant SHALL NOT affect pmem_address/pmem_wdata.
REQ-033 Minimum transaction: grant edge, pmem command for >=1 cycle, resp cycle, return to IDLE; back-to-back grants SHALL have exactly one IDLE cycle between them.
REQ-034 i_rdata/d_rdata SHALL equal pmem_rdata whenever their resp is high; value otherwise don't-care.

Reset
REQ-035 reset=1 SHALL immediately force IDLE, pmem_read=pmem_write=0, i_resp=d_resp=0, last_grant_d=0, latched address/wdata=0, regardless of clock.
REQ-036 Reset mid-transaction SHALL abandon it without resp; first grant after release follows REQ-022..024.

Verification
REQ-037 Single I fill: i_read=1, i_address=0x1230, pmem_resp after 3 cycles -> pmem_read held 3 cycles at 0x1230, i_resp one pulse, i_rdata=pmem_rdata.
REQ-038 Simultaneous i_read and d_read from reset -> D served first, then I after one IDLE cycle, last_grant_d 1 then 0.
REQ-039 Continuous contention for 4 transactions -> grants alternate D,I,D,I.
REQ-040 d_write at 0x8000, wdata 0xA5..A5, d_address changed to 0x0000 after grant -> pmem_write with 0x8000 and 0xA5..A5 until resp.
REQ-041 d_read and d_write both high -> pmem_write only, pmem_read stays 0.
REQ-042 reset asserted mid SERVE_D -> pmem_write drops same cycle, no d_resp, pending i_read granted first after release.
